rgbw_frame_dispatcher: RTL and testbench

Parametrised successor to the fixed-length RGBW byte dispatcher. Receives bytes from the SPI slave receiver via a level `rdy` strobe, hunts for a sync byte, collects a mode byte plus `N_CH` channel bytes into a shadow bank, and commits them atomically to the output registers only when a complete frame has arrived. Adds an inter-byte timeout, error reporting and optional checksum validation. Sits between the SPI receiver and the colour generator / PWM blocks.

---
 rtl/rgbw_frame_dispatcher_if.sv | 18 +
 rtl/rgbw_frame_dispatcher.sv | 190 +++++++++++++++++++
 tb/tb_rgbw_frame_dispatcher.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/rgbw_frame_dispatcher_if.sv
// Byte-in / frame-out bus between the SPI receiver side and rgbw_frame_dispatcher.
interface rgbw_frame_dispatcher_if #(
  parameter int N_CH   = 6,
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0]      buffRx_spi;
  logic                   rdy;
  logic [N_CH*DATA_W-1:0] ch_data;
  logic [DATA_W-1:0]      mode_spi;
  logic                   frame_valid;
  logic                   frame_err;
  logic                   busy;

  modport master (output buffRx_spi, rdy,
                  input  ch_data, mode_spi, frame_valid, frame_err, busy);
  modport slave  (input  buffRx_spi, rdy,
                  output ch_data, mode_spi, frame_valid, frame_err, busy);
endinterface

// File: rtl/rgbw_frame_dispatcher.sv
// Sync-hunting frame collector: shadow-buffers a mode byte plus N_CH channel bytes and commits atomically.
// Optional trailing XOR checksum byte is enabled by defining RGBW_DISP_CHECKSUM_EN.
module rgbw_frame_dispatcher #(
  parameter int                N_CH        = 6,
  parameter int                DATA_W      = 8,
  parameter logic [DATA_W-1:0] SYNC_BYTE   = 8'h55,
  parameter int                TIMEOUT_CYC = 1024
) (
  input logic                    clk,
  input logic                    reset,
  rgbw_frame_dispatcher_if.slave bus
);
  localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CH - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    ST_HUNT = 2'd0,
    ST_MODE = 2'd1,
`ifdef RGBW_DISP_CHECKSUM_EN
    ST_DATA = 2'd2,
    ST_CSUM = 2'd3
`else
    ST_DATA = 2'd2
`endif
  } state_e;

  state_e                 state_r, state_next_s;
  logic                   rdy_latch_r, rdy_prev_r;
  logic [DATA_W-1:0]      data_latch_r;
  logic                   accept_s, tmo_hit_s, commit_s, err_s;
  logic [IDX_W-1:0]       idx_r;
  logic [TMO_W-1:0]       tmo_r;
  logic [DATA_W-1:0]      shadow_r [N_CH];
  logic [DATA_W-1:0]      shadow_mode_r;
  logic [N_CH*DATA_W-1:0] commit_ch_s;
  logic [N_CH*DATA_W-1:0] ch_data_r;
  logic [DATA_W-1:0]      mode_r;
  logic                   frame_valid_r, frame_err_r, busy_r;
`ifdef RGBW_DISP_CHECKSUM_EN
  logic [DATA_W-1:0]      csum_r;

  function automatic logic [DATA_W-1:0] csum_step(input logic [DATA_W-1:0] acc,
                                                  input logic [DATA_W-1:0] b);
    return acc ^ b;
  endfunction
`endif

  assign accept_s  = rdy_latch_r & ~rdy_prev_r;
  assign tmo_hit_s = (state_r != ST_HUNT) && !accept_s && (tmo_r == TMO_LAST);

  // Input stage: resample the rdy level and byte so an edge is detected once per byte.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rdy_latch_r  <= 1'b0;
      rdy_prev_r   <= 1'b0;
      data_latch_r <= '0;
    end else begin
      rdy_latch_r  <= bus.rdy;
      rdy_prev_r   <= rdy_latch_r;
      data_latch_r <= bus.buffRx_spi;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset) state_r <= ST_HUNT;
    else        state_r <= state_next_s;
  end

  // FSM next-state logic; timeout only fires when no byte arrives on the same edge.
  always_comb begin
    state_next_s = state_r;
    if (tmo_hit_s) begin
      state_next_s = ST_HUNT;
    end else if (accept_s) begin
      case (state_r)
        ST_HUNT: state_next_s = (data_latch_r == SYNC_BYTE) ? ST_MODE : ST_HUNT;
        ST_MODE: state_next_s = ST_DATA;
`ifdef RGBW_DISP_CHECKSUM_EN
        ST_DATA: state_next_s = (idx_r == LAST_IDX) ? ST_CSUM : ST_DATA;
        ST_CSUM: state_next_s = ST_HUNT;
`else
        ST_DATA: state_next_s = (idx_r == LAST_IDX) ? ST_HUNT : ST_DATA;
`endif
        default: state_next_s = ST_HUNT;
      endcase
    end else begin
      state_next_s = state_r;
    end
  end

  // FSM outputs: commit and error strobes for the current edge.
  always_comb begin
    commit_s = 1'b0;
    err_s    = 1'b0;
    case (state_r)
      ST_HUNT: begin
        commit_s = 1'b0;
        err_s    = 1'b0;
      end
      ST_MODE: err_s = tmo_hit_s;
      ST_DATA: begin
`ifdef RGBW_DISP_CHECKSUM_EN
        commit_s = 1'b0;
`else
        commit_s = accept_s && (idx_r == LAST_IDX);
`endif
        err_s    = tmo_hit_s;
      end
`ifdef RGBW_DISP_CHECKSUM_EN
      ST_CSUM: begin
        commit_s = accept_s && (data_latch_r == csum_r);
        err_s    = tmo_hit_s || (accept_s && (data_latch_r != csum_r));
      end
`endif
      default: begin
        commit_s = 1'b0;
        err_s    = 1'b0;
      end
    endcase
  end

  // Commit image: the byte arriving on the commit edge bypasses the shadow bank.
  always_comb begin
    commit_ch_s = '0;
    for (int i = 0; i < N_CH; i++) begin
      if ((state_r == ST_DATA) && (IDX_W'(i) == idx_r)) commit_ch_s[i*DATA_W +: DATA_W] = data_latch_r;
      else                                               commit_ch_s[i*DATA_W +: DATA_W] = shadow_r[i];
    end
  end

  // Inter-byte timeout counter, held clear while hunting.
  always_ff @(posedge clk) begin
    if (!reset)                                            tmo_r <= '0;
    else if (accept_s || (state_r == ST_HUNT) || tmo_hit_s) tmo_r <= '0;
    else                                                   tmo_r <= tmo_r + 1'b1;
  end

  // Shadow bank, channel index and running checksum.
  always_ff @(posedge clk) begin
    if (!reset || tmo_hit_s) begin
      for (int i = 0; i < N_CH; i++) shadow_r[i] <= '0;
      shadow_mode_r <= '0;
      idx_r         <= '0;
`ifdef RGBW_DISP_CHECKSUM_EN
      csum_r        <= '0;
`endif
    end else if (accept_s) begin
      if (state_r == ST_MODE) begin
        shadow_mode_r <= data_latch_r;
        idx_r         <= '0;
      end
      if (state_r == ST_DATA) begin
        shadow_r[idx_r] <= data_latch_r;
        if (idx_r != LAST_IDX) idx_r <= idx_r + 1'b1;
      end
`ifdef RGBW_DISP_CHECKSUM_EN
      if (state_r == ST_HUNT)                           csum_r <= '0;
      if ((state_r == ST_MODE) || (state_r == ST_DATA)) csum_r <= csum_step(csum_r, data_latch_r);
`endif
    end
  end

  // Registered frame outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ch_data_r     <= '0;
      mode_r        <= '0;
      frame_valid_r <= 1'b0;
      frame_err_r   <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      frame_valid_r <= commit_s;
      frame_err_r   <= err_s;
      busy_r        <= (state_next_s != ST_HUNT);
      if (commit_s) begin
        ch_data_r <= commit_ch_s;
        mode_r    <= shadow_mode_r;
      end
    end
  end

  assign bus.ch_data     = ch_data_r;
  assign bus.mode_spi    = mode_r;
  assign bus.frame_valid = frame_valid_r;
  assign bus.frame_err   = frame_err_r;
  assign bus.busy        = busy_r;
endmodule

// File: tb/tb_rgbw_frame_dispatcher.sv
// Scoreboard bench: stimulus queues expected commit/error events, per-DUT monitors pop and compare.
module tb_rgbw_frame_dispatcher;
  localparam int TO = 1024;

  typedef struct {
    bit          err;
    logic [47:0] ch;
    logic [11:0] mode;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  exp_t q0[$];
  exp_t q1[$];
  logic [47:0] last0_ch;
  logic [7:0]  last0_mode;

  rgbw_frame_dispatcher_if #(.N_CH(6), .DATA_W(8))  bus0();
  rgbw_frame_dispatcher_if #(.N_CH(3), .DATA_W(12)) bus1();

  rgbw_frame_dispatcher dut0 (.clk(clk), .reset(reset), .bus(bus0));
  rgbw_frame_dispatcher #(.N_CH(3), .DATA_W(12), .SYNC_BYTE(12'hA5A), .TIMEOUT_CYC(TO))
    dut1 (.clk(clk), .reset(reset), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send0(input logic [7:0] b);
    bus0.buffRx_spi = b;
    cyc(2);
    bus0.rdy = 1'b1;
    cyc(3);
    bus0.rdy = 1'b0;
    cyc(2);
  endtask

  task automatic send1(input logic [11:0] b);
    bus1.buffRx_spi = b;
    cyc(2);
    bus1.rdy = 1'b1;
    cyc(3);
    bus1.rdy = 1'b0;
    cyc(2);
  endtask

  task automatic expect_commit0(input logic [7:0] mode, input logic [47:0] ch);
    q0.push_back('{err: 1'b0, ch: ch, mode: {4'h0, mode}});
    last0_ch   = ch;
    last0_mode = mode;
  endtask

  task automatic expect_err0();
    q0.push_back('{err: 1'b1, ch: last0_ch, mode: {4'h0, last0_mode}});
  endtask

  task automatic frame0(input logic [7:0] mode, input logic [47:0] ch);
`ifdef RGBW_DISP_CHECKSUM_EN
    logic [7:0] cs;
    cs = mode;
    for (int i = 0; i < 6; i++) cs = cs ^ ch[i*8 +: 8];
`endif
    expect_commit0(mode, ch);
    send0(8'h55);
    send0(mode);
    chk("busy_mid0", {63'd0, bus0.busy}, 64'd1);
    for (int i = 0; i < 6; i++) send0(ch[i*8 +: 8]);
`ifdef RGBW_DISP_CHECKSUM_EN
    send0(cs);
`endif
    cyc(3);
    chk("drain0", 64'(q0.size()), 64'd0);
    chk("idle_busy0", {63'd0, bus0.busy}, 64'd0);
  endtask

  // Monitor for the default-parameter instance.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus0.frame_valid || bus0.frame_err) begin
        checks++;
        if (q0.size() == 0) begin
          errors++;
          $display("FAIL mon0_unexpected: valid=%0b err=%0b with empty scoreboard", bus0.frame_valid, bus0.frame_err);
        end else begin
          e = q0.pop_front();
          if (bus0.frame_err !== e.err || bus0.frame_valid !== !e.err ||
              bus0.ch_data !== e.ch || {4'h0, bus0.mode_spi} !== e.mode) begin
            errors++;
            $display("FAIL mon0_event: got err=%0b valid=%0b ch=%h mode=%h expected err=%0b ch=%h mode=%h",
                     bus0.frame_err, bus0.frame_valid, bus0.ch_data, bus0.mode_spi, e.err, e.ch, e.mode[7:0]);
          end
        end
      end
    end
  end

  // Monitor for the 3-channel, 12-bit instance.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus1.frame_valid || bus1.frame_err) begin
        checks++;
        if (q1.size() == 0) begin
          errors++;
          $display("FAIL mon1_unexpected: valid=%0b err=%0b with empty scoreboard", bus1.frame_valid, bus1.frame_err);
        end else begin
          e = q1.pop_front();
          if (bus1.frame_err !== e.err || bus1.frame_valid !== !e.err ||
              {12'h0, bus1.ch_data} !== e.ch || bus1.mode_spi !== e.mode) begin
            errors++;
            $display("FAIL mon1_event: got err=%0b valid=%0b ch=%h mode=%h expected err=%0b ch=%h mode=%h",
                     bus1.frame_err, bus1.frame_valid, bus1.ch_data, bus1.mode_spi, e.err, e.ch[35:0], e.mode);
          end
        end
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    last0_ch = '0;
    last0_mode = '0;
    reset = 1'b0;
    bus0.rdy = 1'b0;
    bus0.buffRx_spi = '0;
    bus1.rdy = 1'b0;
    bus1.buffRx_spi = '0;
    cyc(3);
    chk("rst_ch0",    64'(bus0.ch_data), 64'd0);
    chk("rst_mode0",  64'(bus0.mode_spi), 64'd0);
    chk("rst_busy0",  {63'd0, bus0.busy}, 64'd0);
    chk("rst_fv0",    {63'd0, bus0.frame_valid}, 64'd0);
    chk("rst_fe0",    {63'd0, bus0.frame_err}, 64'd0);
    chk("rst_ch1",    64'(bus1.ch_data), 64'd0);
    reset = 1'b1;
    cyc(2);

    // Basic frame 55,01,10..60.
    frame0(8'h01, 48'h605040302010);

    // Leading garbage before sync is skipped.
    send0(8'hAA);
    send0(8'h12);
    chk("hunt_busy0", {63'd0, bus0.busy}, 64'd0);
    frame0(8'h07, 48'hF0E0D0C0B0A0);

    // Sync value inside a frame is plain data.
    frame0(8'h03, 48'h040302015555);

    // Partial frame then silence: timeout error, outputs unchanged.
    expect_err0();
    send0(8'h55);
    send0(8'h01);
    send0(8'h10);
    send0(8'h20);
    cyc(TO - 30);
    chk("tmo_still_busy", {63'd0, bus0.busy}, 64'd1);
    chk("tmo_not_yet",    64'(q0.size()), 64'd1);
    cyc(60);
    chk("tmo_drain",      64'(q0.size()), 64'd0);
    chk("tmo_busy_low",   {63'd0, bus0.busy}, 64'd0);
    chk("tmo_keep_ch",    64'(bus0.ch_data), 64'h040302015555);
    frame0(8'h09, 48'h111213141516);

`ifdef RGBW_DISP_CHECKSUM_EN
    // Hand-computed checksum 06 accepted, 07 rejected.
    expect_commit0(8'h01, 48'h060504030201);
    send0(8'h55); send0(8'h01);
    send0(8'h01); send0(8'h02); send0(8'h03); send0(8'h04); send0(8'h05); send0(8'h06);
    send0(8'h06);
    cyc(3);
    chk("csum_ok_drain", 64'(q0.size()), 64'd0);
    expect_err0();
    send0(8'h55); send0(8'h01);
    send0(8'h01); send0(8'h02); send0(8'h03); send0(8'h04); send0(8'h05); send0(8'h06);
    send0(8'h07);
    cyc(3);
    chk("csum_bad_drain", 64'(q0.size()), 64'd0);
    chk("csum_bad_keep",  64'(bus0.ch_data), 64'h060504030201);
`endif

    // Reset mid-frame clears everything.
    send0(8'h55);
    send0(8'h01);
    send0(8'h10);
    reset = 1'b0;
    cyc(2);
    chk("mid_rst_ch0",   64'(bus0.ch_data), 64'd0);
    chk("mid_rst_mode0", 64'(bus0.mode_spi), 64'd0);
    chk("mid_rst_busy0", {63'd0, bus0.busy}, 64'd0);
    reset = 1'b1;
    last0_ch = '0;
    last0_mode = '0;
    cyc(2);
    frame0(8'h0A, 48'hABCDEF012345);

    // 3-channel 12-bit instance; 055 is not its sync word.
    q1.push_back('{err: 1'b0, ch: 48'h000123800FFF, mode: 12'h001});
    send1(12'h055);
    send1(12'hA5A);
    send1(12'h001);
    chk("busy_mid1", {63'd0, bus1.busy}, 64'd1);
    send1(12'hFFF);
    send1(12'h800);
    send1(12'h123);
`ifdef RGBW_DISP_CHECKSUM_EN
    send1(12'h6DD);
`endif
    cyc(3);
    chk("drain1",     64'(q1.size()), 64'd0);
    chk("idle_busy1", {63'd0, bus1.busy}, 64'd0);
    chk("final_ch1",  64'(bus1.ch_data), 64'h123800FFF);

    cyc(5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
